// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480 @ 60 Hz raster constants and the coordinate type for the VGA timing slice.
package vga_timing_pkg;

    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic bit fits_coord(input int n);
        return (n > 1) && (n <= (1 << COORD_W));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel renderer and DAC pins.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t xPixel;
    coord_t yPixel;
    logic   active_pixels;
    logic   VGA_HS;
    logic   VGA_VS;
    logic   VGA_BLANK_N;
    logic   VGA_SYNC_N;
    logic   line_start;
    logic   frame_start;
    logic   pix_tick;

    modport master (
        output xPixel, yPixel, active_pixels, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, line_start, frame_start, pix_tick
    );

    modport slave (
        input  xPixel, yPixel, active_pixels, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, line_start, frame_start, pix_tick
    );
endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// Wrap counter 0..LIMIT-1 with enable; tc flags the last value so a following stage can chain on it.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int LIMIT = 800
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   tc
);

    assign tc = (count == coord_t'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with registered sync, blank and pixel coordinates.
// Build option: define VGA_TIMING_DIV2_EN to run from a 2x clock with an internal divide-by-2.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             vga_clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    import vga_timing_pkg::*;

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_VIS   = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS   = coord_t'(V_ACTIVE);
    localparam coord_t HS_FROM = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_TO   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_FROM = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_TO   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    if (!fits_coord(LINE_LEN) || !fits_coord(FRAME_LINES)) begin : g_size_err
        $error("vga_timing_gen: raster totals do not fit the coordinate width");
    end

    logic adv;
`ifdef VGA_TIMING_DIV2_EN
    logic div_tog;

    always_ff @(posedge vga_clk) begin
        if (rst) div_tog <= 1'b0;
        else     div_tog <= ~div_tog;
    end

    assign adv = div_tog;
`else
    assign adv = 1'b1;
`endif

    coord_t h_cnt, v_cnt;
    logic   h_tc, v_tc;

    vga_sync_counter #(.LIMIT(LINE_LEN)) u_h_cnt (
        .clk(vga_clk), .rst(rst), .en(adv), .count(h_cnt), .tc(h_tc)
    );

    vga_sync_counter #(.LIMIT(FRAME_LINES)) u_v_cnt (
        .clk(vga_clk), .rst(rst), .en(adv & h_tc), .count(v_cnt), .tc(v_tc)
    );

    logic in_vis, hs_on, vs_on;
    assign in_vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_on  = (h_cnt >= HS_FROM) && (h_cnt < HS_TO);
    assign vs_on  = (v_cnt >= VS_FROM) && (v_cnt < VS_TO);

    // Counters only return to (0,0) through reset or a frame wrap, so track that instead of decoding both.
    logic origin;

    coord_t x_q, y_q;
    logic   act_q, hs_q, vs_q, ls_q, fs_q, tick_q;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            origin <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            act_q  <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= adv;
            if (adv) begin
                origin <= h_tc & v_tc;
                x_q    <= in_vis ? h_cnt : '0;
                y_q    <= in_vis ? v_cnt : '0;
                act_q  <= in_vis;
                hs_q   <= hs_on ? HS_POL : ~HS_POL;
                vs_q   <= vs_on ? VS_POL : ~VS_POL;
                ls_q   <= (h_cnt == '0);
                fs_q   <= origin;
            end
        end
    end

    assign vga.xPixel        = x_q;
    assign vga.yPixel        = y_q;
    assign vga.active_pixels = act_q;
    assign vga.VGA_BLANK_N   = act_q;
    assign vga.VGA_HS        = hs_q;
    assign vga.VGA_VS        = vs_q;
    assign vga.VGA_SYNC_N    = 1'b0;
    assign vga.line_start    = ls_q;
    assign vga.frame_start   = fs_q;
    assign vga.pix_tick      = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/line timing, shrunken raster instance for frame, wrap and mid-frame reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_TIMING_DIV2_EN
    localparam int CPP = 2;
`else
    localparam int CPP = 1;
`endif

    // shrunken raster: 16 x 12 total, 8 x 6 visible, HS at h 10..12 (active high), VS at v 8..9
    localparam int S_HT = 16;
    localparam int S_VT = 12;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    vga_timing_gen_if vga();
    vga_timing_gen_if vga_s();

    vga_timing_gen dut (.vga_clk(clk), .rst(rst), .vga(vga));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_s (.vga_clk(clk), .rst(rst_s), .vga(vga_s));

    task automatic next_pos();
        repeat (CPP) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [27:0] obs;
        repeat (3) @(negedge clk);
        obs = {vga.xPixel, vga.yPixel, vga.active_pixels, vga.VGA_BLANK_N, vga.VGA_HS, vga.VGA_VS,
               vga.VGA_SYNC_N, vga.line_start, vga.frame_start, vga.pix_tick};
        checks++;
        if (obs !== {10'd0, 10'd0, 8'b0011_0000}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, {10'd0, 10'd0, 8'b0011_0000});
        end
        obs = {vga_s.xPixel, vga_s.yPixel, vga_s.active_pixels, vga_s.VGA_BLANK_N, vga_s.VGA_HS, vga_s.VGA_VS,
               vga_s.VGA_SYNC_N, vga_s.line_start, vga_s.frame_start, vga_s.pix_tick};
        checks++;
        if (obs !== {10'd0, 10'd0, 8'b0001_0000}) begin
            errors++;
            $display("FAIL reset_values_pol: got %h expected %h", obs, {10'd0, 10'd0, 8'b0001_0000});
        end
        rst = 1'b0;
`ifdef VGA_TIMING_DIV2_EN
        @(negedge clk);
        checks++;
        if ({vga.active_pixels, vga.pix_tick} !== 2'b00) begin
            errors++;
            $display("FAIL first_edge_hold: got %b expected 00", {vga.active_pixels, vga.pix_tick});
        end
        @(negedge clk);
`else
        @(negedge clk);
`endif
        obs = {vga.xPixel, vga.yPixel, vga.active_pixels, vga.VGA_BLANK_N, vga.VGA_HS, vga.VGA_VS,
               vga.VGA_SYNC_N, vga.line_start, vga.frame_start, vga.pix_tick};
        checks++;
        if (obs !== {10'd0, 10'd0, 8'b1111_0111}) begin
            errors++;
            $display("FAIL first_position: got %h expected %h", obs, {10'd0, 10'd0, 8'b1111_0111});
        end
    endtask

    task automatic test_line();
        int act_n = 0, hs_n = 0, hs_first = -1, ls_n = 0, fs_n = 0;
        int x_bad = 0, y_bad = 0, blank_bad = 0, vs_bad = 0, tick_bad = 0;
        for (int p = 0; p < 800; p++) begin
            if (vga.active_pixels === 1'b1) act_n++;
            if (vga.VGA_HS === 1'b0) begin
                if (hs_first < 0) hs_first = p;
                hs_n++;
            end
            if (vga.line_start === 1'b1) ls_n++;
            if (vga.frame_start === 1'b1) fs_n++;
            if (vga.xPixel !== ((p < 640) ? 10'(p) : 10'd0)) x_bad++;
            if (vga.yPixel !== 10'd0) y_bad++;
            if (vga.VGA_BLANK_N !== (p < 640)) blank_bad++;
            if (vga.VGA_VS !== 1'b1) vs_bad++;
            if (vga.pix_tick !== 1'b1) tick_bad++;
            next_pos();
        end
        checks++; if (act_n !== 640) begin errors++; $display("FAIL line_active_len: got %0d expected 640", act_n); end
        checks++; if (hs_n !== 96) begin errors++; $display("FAIL line_hs_len: got %0d expected 96", hs_n); end
        checks++; if (hs_first !== 656) begin errors++; $display("FAIL line_hs_start: got %0d expected 656", hs_first); end
        checks++; if (ls_n !== 1) begin errors++; $display("FAIL line_start_count: got %0d expected 1", ls_n); end
        checks++; if (fs_n !== 1) begin errors++; $display("FAIL line_frame_start_count: got %0d expected 1", fs_n); end
        checks++; if (x_bad !== 0) begin errors++; $display("FAIL line_xpixel: got %0d bad positions expected 0", x_bad); end
        checks++; if (y_bad !== 0) begin errors++; $display("FAIL line_ypixel: got %0d bad positions expected 0", y_bad); end
        checks++; if (blank_bad !== 0) begin errors++; $display("FAIL line_blank_n: got %0d bad positions expected 0", blank_bad); end
        checks++; if (vs_bad !== 0) begin errors++; $display("FAIL line_vs_idle: got %0d bad positions expected 0", vs_bad); end
        checks++; if (tick_bad !== 0) begin errors++; $display("FAIL line_pix_tick: got %0d bad positions expected 0", tick_bad); end
        checks++;
        if ({vga.xPixel, vga.yPixel, vga.active_pixels, vga.line_start, vga.frame_start} !== {10'd0, 10'd1, 3'b110}) begin
            errors++;
            $display("FAIL line_next: got x=%0d y=%0d act=%b ls=%b fs=%b expected x=0 y=1 act=1 ls=1 fs=0",
                     vga.xPixel, vga.yPixel, vga.active_pixels, vga.line_start, vga.frame_start);
        end
    endtask

`ifdef VGA_TIMING_DIV2_EN
    task automatic test_div2();
        int hold_bad = 0, tick_bad = 0, ls_hold = 0;
        logic [9:0] x0;
        logic       ls0;
        for (int p = 0; p < 20; p++) begin
            if (vga.pix_tick !== 1'b1) tick_bad++;
            x0  = vga.xPixel;
            ls0 = vga.line_start;
            @(negedge clk);
            if (vga.pix_tick !== 1'b0) tick_bad++;
            if (vga.xPixel !== x0 || vga.line_start !== ls0) hold_bad++;
            if (p == 0 && vga.line_start === 1'b1) ls_hold++;
            @(negedge clk);
        end
        checks++; if (tick_bad !== 0) begin errors++; $display("FAIL div2_tick_alternate: got %0d bad clocks expected 0", tick_bad); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL div2_hold: got %0d bad positions expected 0", hold_bad); end
        checks++; if (ls_hold !== 1) begin errors++; $display("FAIL div2_line_start_2clk: got %0d expected 1", ls_hold); end
    endtask
`endif

    task automatic test_frame();
        int h, v;
        int x_bad = 0, y_bad = 0, act_bad = 0, hs_bad = 0, ls_bad = 0;
        int fs_n = 0, fs_pos_bad = 0, vs_n = 0, vs_first = -1, x_max = 0, y_max = 0;
        rst_s = 1'b0;
        next_pos();
        for (int p = 0; p <= 3 * S_HT * S_VT; p++) begin
            h = p % S_HT;
            v = (p / S_HT) % S_VT;
            if (vga_s.active_pixels !== (h < 8 && v < 6)) act_bad++;
            if (vga_s.xPixel !== ((h < 8 && v < 6) ? 10'(h) : 10'd0)) x_bad++;
            if (vga_s.yPixel !== ((h < 8 && v < 6) ? 10'(v) : 10'd0)) y_bad++;
            if (vga_s.VGA_HS !== (h >= 10 && h < 13)) hs_bad++;
            if (vga_s.line_start !== (h == 0)) ls_bad++;
            if (vga_s.frame_start === 1'b1) begin
                fs_n++;
                if (p % (S_HT * S_VT) != 0) fs_pos_bad++;
            end
            if (p < S_HT * S_VT && vga_s.VGA_VS === 1'b0) begin
                if (vs_first < 0) vs_first = p;
                vs_n++;
            end
            if (int'(vga_s.xPixel) > x_max) x_max = int'(vga_s.xPixel);
            if (int'(vga_s.yPixel) > y_max) y_max = int'(vga_s.yPixel);
            if (p != 3 * S_HT * S_VT) next_pos();
        end
        checks++; if (act_bad !== 0) begin errors++; $display("FAIL frame_active: got %0d bad positions expected 0", act_bad); end
        checks++; if (x_bad !== 0) begin errors++; $display("FAIL frame_xpixel: got %0d bad positions expected 0", x_bad); end
        checks++; if (y_bad !== 0) begin errors++; $display("FAIL frame_ypixel: got %0d bad positions expected 0", y_bad); end
        checks++; if (hs_bad !== 0) begin errors++; $display("FAIL frame_hs: got %0d bad positions expected 0", hs_bad); end
        checks++; if (ls_bad !== 0) begin errors++; $display("FAIL frame_line_start: got %0d bad positions expected 0", ls_bad); end
        checks++; if (fs_n !== 4 || fs_pos_bad !== 0) begin errors++; $display("FAIL frame_start_period: got %0d pulses %0d misplaced expected 4 pulses 0 misplaced", fs_n, fs_pos_bad); end
        checks++; if (vs_n !== 32) begin errors++; $display("FAIL frame_vs_len: got %0d expected 32", vs_n); end
        checks++; if (vs_first !== 128) begin errors++; $display("FAIL frame_vs_start: got %0d expected 128", vs_first); end
        checks++; if (x_max !== 7 || y_max !== 5) begin errors++; $display("FAIL frame_coord_max: got x=%0d y=%0d expected x=7 y=5", x_max, y_max); end
    endtask

    task automatic test_mid_reset();
        logic [27:0] obs;
        // currently presenting (0,0); move to h=11, v=8 where both syncs are asserted
        repeat (8 * S_HT + 11) next_pos();
        checks++;
        if ({vga_s.VGA_HS, vga_s.VGA_VS, vga_s.active_pixels} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_pre_sync: got %b expected 100", {vga_s.VGA_HS, vga_s.VGA_VS, vga_s.active_pixels});
        end
        rst_s = 1'b1;
        @(negedge clk);
        obs = {vga_s.xPixel, vga_s.yPixel, vga_s.active_pixels, vga_s.VGA_BLANK_N, vga_s.VGA_HS, vga_s.VGA_VS,
               vga_s.VGA_SYNC_N, vga_s.line_start, vga_s.frame_start, vga_s.pix_tick};
        checks++;
        if (obs !== {10'd0, 10'd0, 8'b0001_0000}) begin
            errors++;
            $display("FAIL midreset_values: got %h expected %h", obs, {10'd0, 10'd0, 8'b0001_0000});
        end
        rst_s = 1'b0;
        next_pos();
        obs = {vga_s.xPixel, vga_s.yPixel, vga_s.active_pixels, vga_s.VGA_BLANK_N, vga_s.VGA_HS, vga_s.VGA_VS,
               vga_s.VGA_SYNC_N, vga_s.line_start, vga_s.frame_start, vga_s.pix_tick};
        checks++;
        if (obs !== {10'd0, 10'd0, 8'b1101_0111}) begin
            errors++;
            $display("FAIL midreset_restart: got %h expected %h", obs, {10'd0, 10'd0, 8'b1101_0111});
        end
    endtask

    initial begin
        test_reset();
        test_line();
`ifdef VGA_TIMING_DIV2_EN
        test_div2();
`endif
        test_frame();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing: horizontal and vertical counters, sync pulses, blanking and the pixel coordinate / active-region signals consumed by the pixel renderer (`daw_main_screen` and successors). Sits in the top level between the pixel clock and the renderer/DAC pins. It is the producer end of the `xPixel`/`yPixel`/`active_pixels` interface.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, asserted level of `VGA_HS`
- `VS_POL`, 0, asserted level of `VGA_VS`

Ports:
- `vga_clk` in 1: single clock. It is 25 MHz, or 50 MHz when the divide feature is built in.
- `rst` in 1: synchronous, active-high reset.
- `xPixel` out 10: column. Equals the horizontal count when `active_pixels` is high, otherwise 0.
- `yPixel` out 10: row. Equals the vertical count when `active_pixels` is high, otherwise 0.
- `active_pixels` out 1: position is inside the visible area.
- `VGA_HS` out 1: horizontal sync.
- `VGA_VS` out 1: vertical sync.
- `VGA_BLANK_N` out 1: equals `active_pixels`.
- `VGA_SYNC_N` out 1: constant 0.
- `line_start` out 1: pulse at h=0 of every line, including blank lines.
- `frame_start` out 1: pulse at h=0, v=0.
- `pix_tick` out 1: the outputs advanced this cycle.

## Operation
- Internal counters:
  - `h_cnt` runs 0..H_TOTAL-1 with H_TOTAL = 800.
  - `v_cnt` runs 0..V_TOTAL-1 with V_TOTAL = 525.
  - Both are 10 bits and unsigned. Sizes are checked by the package constants.
- On each advance, `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `v_cnt` = V_TOTAL-1 with `h_cnt` = H_TOTAL-1, both counters wrap to 0 (frame wrap).
- Decode, evaluated on the counter values being presented:
  - active when h < 640 and v < 480.
  - HS asserted when 656 ≤ h < 752.
  - VS asserted when 490 ≤ v < 492, for the whole line including h ≥ 640.
- All outputs are registered. There is no combinational path from counters to ports.
- Reset values while `rst` is high:
  - counters = 0.
  - `xPixel` = 0, `yPixel` = 0.
  - `active_pixels` = 0, `VGA_BLANK_N` = 0.
  - `VGA_HS` = !HS_POL, `VGA_VS` = !VS_POL.
  - `line_start` = 0, `frame_start` = 0, `pix_tick` = 0.
- Reset asserted mid-frame aborts the frame. The next post-reset edge restarts at (0,0). No partial sync pulse is extended.

## Timing
- Cycle k = first rising edge with `rst` sampled low.
  - After edge k, outputs present position (0,0): `active_pixels`=1, `frame_start`=1, `line_start`=1.
  - Each subsequent advance presents the next raster position.
- All outputs for one position change on the same edge. Sync, blank and coordinates are mutually aligned with zero skew.
- The renderer is combinational, so RGB for a position is valid in the same cycle as its coordinates.
- Frame period is 420000 advances. Line period is 800 advances.
- `frame_start` and `line_start` are high for exactly the cycles presenting their position. Without the divide feature that is one cycle.

## Configuration
- `VGA_TIMING_DIV2_EN` defined:
  - `vga_clk` is 50 MHz. An internal toggle divides it, starting at 0 at reset.
  - The position advances only on cycles where the toggle is 1. `pix_tick`=1 on those cycles, so the first advance is at edge k+1.
  - Outputs hold for 2 clocks. `frame_start` and `line_start` stay high for both clocks of their position.
- Undefined:
  - Every non-reset edge advances. `pix_tick`=1 on every non-reset cycle.

## Structure
- Package `vga_timing_pkg` holds:
  - the 640x480 porch/sync constants and derived H_TOTAL/V_TOTAL, HS_START/HS_END and VS_START/VS_END.
  - a 10-bit coordinate typedef.
- One sub-module, `vga_sync_counter`: a wrap counter with enable, parameterized limit and a terminal-count output.
  - Instantiated twice. The horizontal instance's terminal count enables the vertical instance.

## Test plan
- Reset release: hold `rst` 3 cycles, then release.
  - During reset all outputs are at their reset values.
  - First post-reset edge gives (0,0), `active_pixels`=1, `frame_start`=1.
- Line timing: count from `line_start`.
  - `active_pixels` high for 640 advances.
  - `VGA_HS` low from h=656 for 96 advances.
  - Next `line_start` at advance 800.
- Frame timing:
  - `VGA_VS` low for exactly 1600 advances, starting at v=490, h=0.
  - `frame_start` repeats every 420000 advances.
  - `yPixel` max = 479 and `xPixel` max = 639. Both are 0 whenever `active_pixels`=0.
- Wrap: at h=799, v=524 the next advance gives (0,0) with `frame_start`=1. No position is skipped or repeated.
- Mid-frame reset: assert `rst` at v=300, h=400 for 1 cycle.
  - Outputs go to reset values on that edge.
  - Next edge presents (0,0).
- With `VGA_TIMING_DIV2_EN`:
  - `pix_tick` alternates 0,1.
  - Each position is held 2 clocks.
  - Frame = 840000 clocks.
